// File: rtl/sw_pkg.sv
// sw_pkg: shared defaults and counter-width helper for the switch debouncer
package sw_pkg;

    localparam int SW_N_DEFAULT        = 3;
    localparam int SW_DEBOUNCE_DEFAULT = 1_000_000;

    function automatic int cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// sw_debounce_ch: one switch channel - synchronizer, stability counter, accepted level, edge pulses
module sw_debounce_ch
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_rise,
    output logic sw_fall
);

    localparam int                CNT_W    = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d, s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d, fall_q, fall_d;
    logic             differ, accept;

    // A differing synchronized level must persist for DEBOUNCE_CYCLES edges; any agreeing cycle restarts the count
    always_comb begin
        s1_d     = sw_raw;
        s2_d     = s1_q;
        differ   = s2_q != stable_q;
        accept   = differ && cnt_q == CNT_LAST;
        cnt_d    = (differ && !accept) ? cnt_q + CNT_W'(1) : '0;
        stable_d = accept ? s2_q : stable_q;
        rise_d   = accept && s2_q;
        fall_d   = accept && !s2_q;
    end

    // All channel state clears on reset, so a held-high switch is re-debounced after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sw_db   = stable_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: N_SW independent debounced switch channels with rise/fall pulses
module sw_debounce
    import sw_pkg::*;
#(
    parameter int N_SW            = SW_N_DEFAULT,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall
);

    for (genvar g = 0; g < N_SW; g++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw_raw (sw_raw[g]),
            .sw_db  (sw_db[g]),
            .sw_rise(sw_rise[g]),
            .sw_fall(sw_fall[g])
        );
    end

endmodule
